router_sync_n: RTL and testbench
================================

Name: router_sync_n

Overview:
- Parametrised N-channel synchroniser between the router FSM and its output FIFOs.
- Latches the destination address when a header is detected.
- Steers the one-hot FIFO write enable and the selected FIFO's full flag back to the FSM.
- Runs an independent read-timeout watchdog on every channel and pulses that channel's soft reset when a packet sits unread too long; invalid destination addresses are flagged instead of silently dropped.

Parameters:
- NUM_CH, 3, number of output channels/FIFOs (2..16).
- ADDR_W, 2, width of destination address field; must satisfy 2**ADDR_W >= NUM_CH.
- TIMEOUT, 30, consecutive unread-valid cycles before soft reset (2..2**CNT_W-1).
- CNT_W, 5, watchdog counter width.

Ports:
- clk  in  1  system clock, all state on rising edge.
- resetn  in  1  asynchronous, active-low reset.
- detect_add  in  1  header byte present; capture data_in this cycle.
- data_in  in  ADDR_W  destination address from header.
- write_enb_reg  in  1  FSM request to write current byte to selected FIFO.
- read_enb  in  NUM_CH  per-channel read strobe from downstream.
- full  in  NUM_CH  per-FIFO full flag.
- empty  in  NUM_CH  per-FIFO empty flag.
- valid_out  out  NUM_CH  per-channel data available.
- write_enb  out  NUM_CH  one-hot FIFO write enable.
- fifo_full  out  1  full flag of currently addressed FIFO.
- soft_reset  out  NUM_CH  per-channel one-cycle flush pulse.
- addr_err  out  1  one-cycle pulse: captured address >= NUM_CH.

Behaviour:
- Reset (resetn low, asynchronous): addr_q=0, addr_vld_q=0, all cnt[k]=0, soft_reset=0, addr_err=0.
- Reset effect on outputs: write_enb=0 and fifo_full=0, because addr_vld_q=0. valid_out still tracks ~empty.
- Reset mid-packet: drops the address immediately; no write_enb until the next detect_add.
- Address capture: on a clk edge with detect_add=1, addr_q<=data_in and addr_vld_q<=(data_in<NUM_CH).
- addr_err is registered: it is 1 in the cycle after a capture with data_in>=NUM_CH, else 0.
- A held address persists until the next detect_add.
- detect_add on back-to-back cycles: last capture wins.
- valid_out[k] = ~empty[k], combinational.
- write_enb is combinational: one-hot(addr_q) when write_enb_reg & addr_vld_q, else all zero.
- write_enb_reg in the same cycle as detect_add uses the previous addr_q; the new address takes effect the following cycle.
- write_enb is never multi-hot.
- fifo_full is combinational: full[addr_q] when addr_vld_q, else 0.
- Watchdog, per channel k, independent of addr_q. All channels run concurrently.
  - If empty[k] | read_enb[k] | soft_reset[k]: cnt[k]<=0.
  - Else if cnt[k]==TIMEOUT-1: cnt[k]<=0 and soft_reset[k]<=1.
  - Else: cnt[k]<=cnt[k]+1 and soft_reset[k]<=0.
  - In every other case soft_reset[k]<=0.
- Result: soft_reset[k] is high for exactly one cycle, in the cycle after the TIMEOUT-th consecutive valid-and-not-read cycle.
- After a pulse, the counter restarts from 0. If the FIFO is still non-empty and unread, another pulse follows TIMEOUT+1 cycles later.
- read_enb[k] in the would-be terminal cycle wins: counter clears and no pulse.
- Counter never wraps: the maximum value is TIMEOUT-1.
- Width rules: out-of-range addresses never index full[] or write_enb; the implementation must guard the index explicitly.
- Elaboration: the implementation must fail elaboration (static check) if 2**ADDR_W<NUM_CH or TIMEOUT>=2**CNT_W.

Test Plan:
- Reset/async (defaults): drive write_enb_reg=1 and empty=0; pulse resetn low between clk edges -> outputs clear immediately; write_enb=000, fifo_full=0, soft_reset=000.
- Steering (defaults): detect_add with data_in=2, then write_enb_reg=1 for 4 cycles, full=3'b100 -> write_enb=3'b100 for those 4 cycles, fifo_full=1.
- Steering, same-cycle header: detect_add and write_enb_reg together -> that cycle uses the old address.
- Invalid address: data_in=3 with NUM_CH=3 -> addr_err=1 for one cycle, write_enb=000 and fifo_full=0 despite write_enb_reg=1, until a valid detect_add.
- Timeout: empty[1]=0, read_enb[1]=0 held -> soft_reset[1]=1 only in cycle 31 (30 idle edges), 0 elsewhere; second pulse in cycle 62.
- Timeout, late read: read_enb[1]=1 at cycle 30 -> no pulse.
- Concurrency: channels 0 and 2 both stalled from the same edge while addr_q=1 -> soft_reset 3'b101 in the same cycle. Separately, NUM_CH=5, ADDR_W=3, TIMEOUT=4: one-hot write_enb for addresses 0..4, addr_err for 5..7, pulse after 4 idle cycles.

Source files
------------

// File: rtl/router_sync_n.sv
// router_sync_n: N-channel synchroniser between the router FSM and its output FIFOs.
// Captures the destination address, steers FIFO write/full, and runs per-channel read watchdogs.
`default_nettype none

module router_sync_n #(
    parameter int NUM_CH  = 3,
    parameter int ADDR_W  = 2,
    parameter int TIMEOUT = 30,
    parameter int CNT_W   = 5
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              detect_add,
    input  logic [ADDR_W-1:0] data_in,
    input  logic              write_enb_reg,
    input  logic [NUM_CH-1:0] read_enb,
    input  logic [NUM_CH-1:0] full,
    input  logic [NUM_CH-1:0] empty,
    output logic [NUM_CH-1:0] valid_out,
    output logic [NUM_CH-1:0] write_enb,
    output logic              fifo_full,
    output logic [NUM_CH-1:0] soft_reset,
    output logic              addr_err
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);

    generate
        if ((2 ** ADDR_W) < NUM_CH) begin : g_bad_addr_w
            $error("router_sync_n: ADDR_W too narrow for NUM_CH");
        end
        if (TIMEOUT >= (2 ** CNT_W)) begin : g_bad_cnt_w
            $error("router_sync_n: TIMEOUT does not fit in CNT_W");
        end
    endgenerate

    logic [ADDR_W-1:0] addr_q;
    logic              addr_vld_q;
    logic              data_in_ok;

    assign data_in_ok = (32'(data_in) < NUM_CH);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            addr_q     <= '0;
            addr_vld_q <= 1'b0;
            addr_err   <= 1'b0;
        end else begin
            addr_err <= detect_add & ~data_in_ok;
            if (detect_add) begin
                addr_q     <= data_in;
                addr_vld_q <= data_in_ok;
            end
        end
    end

    assign valid_out = ~empty;

    // Explicit compare per channel so an out-of-range address can never select anything.
    always_comb begin
        write_enb = '0;
        fifo_full = 1'b0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (addr_vld_q && (32'(addr_q) == k)) begin
                write_enb[k] = write_enb_reg;
                fifo_full    = full[k];
            end
        end
    end

    generate
        for (genvar k = 0; k < NUM_CH; k++) begin : g_wd
            logic [CNT_W-1:0] cnt;
            logic             soft_q;

            always_ff @(posedge clk or negedge resetn) begin
                if (!resetn) begin
                    cnt    <= '0;
                    soft_q <= 1'b0;
                end else if (empty[k] | read_enb[k] | soft_q) begin
                    cnt    <= '0;
                    soft_q <= 1'b0;
                end else if (cnt == CNT_MAX) begin
                    cnt    <= '0;
                    soft_q <= 1'b1;
                end else begin
                    cnt    <= cnt + 1'b1;
                    soft_q <= 1'b0;
                end
            end

            assign soft_reset[k] = soft_q;
        end
    endgenerate

endmodule

`default_nettype wire

// File: tb/tb_router_sync_n.sv
// tb_router_sync_n: directed self-checking bench for router_sync_n (default and 5-channel builds).
`default_nettype none

module tb_router_sync_n;

    logic       clk = 1'b0;
    logic       resetn;
    always #5 clk = ~clk;

    // Default build: NUM_CH=3, ADDR_W=2, TIMEOUT=30
    logic       detect_add, write_enb_reg;
    logic [1:0] data_in;
    logic [2:0] read_enb, full, empty;
    logic [2:0] valid_out, write_enb, soft_reset;
    logic       fifo_full, addr_err;

    router_sync_n u_dut (
        .clk(clk), .resetn(resetn), .detect_add(detect_add), .data_in(data_in),
        .write_enb_reg(write_enb_reg), .read_enb(read_enb), .full(full), .empty(empty),
        .valid_out(valid_out), .write_enb(write_enb), .fifo_full(fifo_full),
        .soft_reset(soft_reset), .addr_err(addr_err)
    );

    // Second build: NUM_CH=5, ADDR_W=3, TIMEOUT=4
    logic       b_detect_add, b_write_enb_reg;
    logic [2:0] b_data_in;
    logic [4:0] b_read_enb, b_full, b_empty;
    logic [4:0] b_valid_out, b_write_enb, b_soft_reset;
    logic       b_fifo_full, b_addr_err;

    router_sync_n #(.NUM_CH(5), .ADDR_W(3), .TIMEOUT(4), .CNT_W(3)) u_dut5 (
        .clk(clk), .resetn(resetn), .detect_add(b_detect_add), .data_in(b_data_in),
        .write_enb_reg(b_write_enb_reg), .read_enb(b_read_enb), .full(b_full), .empty(b_empty),
        .valid_out(b_valid_out), .write_enb(b_write_enb), .fifo_full(b_fifo_full),
        .soft_reset(b_soft_reset), .addr_err(b_addr_err)
    );

    int vectors = 0;
    int errors  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        resetn = 1'b0;
        detect_add = 1'b0; data_in = '0; write_enb_reg = 1'b0;
        read_enb = '0; full = '0; empty = 3'b111;
        b_detect_add = 1'b0; b_data_in = '0; b_write_enb_reg = 1'b0;
        b_read_enb = '0; b_full = '0; b_empty = 5'b11111;
        #12;
        chk("rst_write_enb", write_enb, 3'b000);
        chk("rst_fifo_full", fifo_full, 1'b0);
        chk("rst_soft_reset", soft_reset, 3'b000);
        chk("rst_addr_err", addr_err, 1'b0);
        chk("rst_valid_out", valid_out, 3'b000);
        resetn = 1'b1;
        step();

        // Steering to channel 2
        detect_add = 1'b1; data_in = 2'd2;
        step();
        detect_add = 1'b0; write_enb_reg = 1'b1; full = 3'b100;
        #1;
        for (int i = 0; i < 4; i++) begin
            chk("steer_write_enb", write_enb, 3'b100);
            chk("steer_fifo_full", fifo_full, 1'b1);
            step();
        end
        empty = 3'b010;
        #1;
        chk("valid_out", valid_out, 3'b101);
        empty = 3'b111;

        // Header and write in the same cycle: old address still steers
        detect_add = 1'b1; data_in = 2'd0;
        #1;
        chk("same_cycle_old_addr", write_enb, 3'b100);
        step();
        detect_add = 1'b0;
        #1;
        chk("same_cycle_new_addr", write_enb, 3'b001);
        chk("same_cycle_fifo_full", fifo_full, 1'b0);

        // Invalid address
        full = 3'b111;
        detect_add = 1'b1; data_in = 2'd3;
        step();
        detect_add = 1'b0;
        chk("inv_addr_err", addr_err, 1'b1);
        chk("inv_write_enb", write_enb, 3'b000);
        chk("inv_fifo_full", fifo_full, 1'b0);
        step();
        chk("inv_addr_err_drop", addr_err, 1'b0);
        chk("inv_write_enb_held", write_enb, 3'b000);
        detect_add = 1'b1; data_in = 2'd1;
        step();
        detect_add = 1'b0;
        chk("valid_again_addr_err", addr_err, 1'b0);
        chk("valid_again_write_enb", write_enb, 3'b010);
        chk("valid_again_fifo_full", fifo_full, 1'b1);

        // Asynchronous reset between edges
        empty = 3'b000;
        step();
        #2;
        resetn = 1'b0;
        #1;
        chk("async_write_enb", write_enb, 3'b000);
        chk("async_fifo_full", fifo_full, 1'b0);
        chk("async_soft_reset", soft_reset, 3'b000);
        chk("async_valid_out", valid_out, 3'b111);
        empty = 3'b101;
        #1;
        resetn = 1'b1;
        step();
        chk("post_rst_no_write", write_enb, 3'b000);

        // Timeout on channel 1: counting started at the edge just taken
        for (int i = 2; i <= 62; i++) begin
            step();
            chk("timeout_ch1", soft_reset, (i == 30 || i == 61) ? 3'b010 : 3'b000);
        end

        // Late read in the would-be terminal cycle suppresses the pulse
        for (int i = 1; i <= 29; i++) begin
            step();
            chk("late_read_pre", soft_reset, 3'b000);
        end
        read_enb = 3'b010;
        step();
        chk("late_read_terminal", soft_reset, 3'b000);
        read_enb = 3'b000;
        step();
        chk("late_read_after", soft_reset, 3'b000);

        // Concurrent stall of channels 0 and 2 with addr_q=1
        empty = 3'b111;
        detect_add = 1'b1; data_in = 2'd1;
        step();
        detect_add = 1'b0;
        empty = 3'b010;
        for (int i = 1; i <= 31; i++) begin
            step();
            chk("concurrent", soft_reset, (i == 30) ? 3'b101 : 3'b000);
        end
        chk("concurrent_steer", write_enb, 3'b010);

        // Five-channel build
        empty = 3'b111;
        b_write_enb_reg = 1'b1;
        b_full = 5'b01000;
        for (int a = 0; a < 8; a++) begin
            b_detect_add = 1'b1; b_data_in = 3'(a);
            step();
            b_detect_add = 1'b0;
            chk("b_addr_err", b_addr_err, (a >= 5) ? 1'b1 : 1'b0);
            chk("b_write_enb", b_write_enb, (a < 5) ? (32'd1 << a) : 32'd0);
            chk("b_fifo_full", b_fifo_full, (a == 3) ? 1'b1 : 1'b0);
        end
        b_empty = 5'b11110;
        for (int i = 1; i <= 6; i++) begin
            step();
            chk("b_timeout", b_soft_reset, (i == 4) ? 5'b00001 : 5'b00000);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

`default_nettype wire
